// File: rtl/reg_file_sb.sv
// Integer register file with write-back scoreboard: NRD combinational reads, NWR write-back ports,
// per-register busy/tag tracking. Define REGFILE_BYPASS_EN to forward committing write-backs to reads.
module reg_file_sb #(
   parameter  int XLEN  = 64,
   parameter  int NREGS = 32,
   parameter  int NRD   = 2,
   parameter  int NWR   = 2,
   parameter  int TAG_W = 4,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [NRD*AW-1:0]     rd_addr_i,
   output logic [NRD*XLEN-1:0]   rd_data_o,
   output logic [NRD-1:0]        rd_busy_o,
   input  logic                  iss_valid_i,
   input  logic [AW-1:0]         iss_rd_i,
   input  logic [TAG_W-1:0]      iss_tag_i,
   input  logic [NWR-1:0]        wb_valid_i,
   input  logic [NWR*AW-1:0]     wb_addr_i,
   input  logic [NWR*XLEN-1:0]   wb_data_i,
   input  logic [NWR*TAG_W-1:0]  wb_tag_i,
   input  logic [NWR-1:0]        wb_sext32_i,
   output logic [NWR-1:0]        wb_drop_o,
   input  logic                  flush_i
);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  regs_d [NREGS];
   logic [TAG_W-1:0] tag_q  [NREGS];
   logic [TAG_W-1:0] tag_d  [NREGS];
   logic [NREGS-1:0] busy_q, busy_d;
   logic [NWR-1:0]   wb_drop_q, wb_drop_d;

   logic [AW-1:0]    wb_a   [NWR];
   logic [XLEN-1:0]  wb_raw [NWR];
   logic [XLEN-1:0]  wb_w   [NWR];
   logic [TAG_W-1:0] wb_t   [NWR];
   logic [NWR-1:0]   wb_hit, wb_tmatch, wb_commit, wb_match;
   logic [AW-1:0]    rd_a   [NRD];

   // Write-back qualification is judged against pre-edge busy/tag, so a
   // concurrent flush or issue never affects whether a write-back commits.
   always_comb begin
      wb_hit    = '0;
      wb_tmatch = '0;
      wb_commit = '0;
      wb_match  = '0;
      wb_drop_d = '0;
      for (int j = 0; j < NWR; j++) begin
         wb_a[j]   = wb_addr_i[j*AW +: AW];
         wb_raw[j] = wb_data_i[j*XLEN +: XLEN];
         wb_t[j]   = wb_tag_i[j*TAG_W +: TAG_W];
         wb_w[j]   = wb_sext32_i[j] ? XLEN'($signed(wb_raw[j][31:0])) : wb_raw[j];
         wb_hit[j]    = wb_valid_i[j] && (wb_a[j] != '0);
         wb_tmatch[j] = (tag_q[wb_a[j]] == wb_t[j]);
         wb_commit[j] = wb_hit[j] && (!busy_q[wb_a[j]] || wb_tmatch[j]);
         wb_match[j]  = wb_hit[j] && busy_q[wb_a[j]] && wb_tmatch[j];
         wb_drop_d[j] = wb_hit[j] && !wb_commit[j];
      end
   end

   // Ascending port order lets the highest committing port win the data;
   // issue is applied last so it overrides both flush and busy clears.
   always_comb begin
      regs_d = regs_q;
      tag_d  = tag_q;
      busy_d = flush_i ? '0 : busy_q;
      for (int j = 0; j < NWR; j++) begin
         if (wb_commit[j]) begin
            regs_d[wb_a[j]] = wb_w[j];
         end
         if (wb_match[j]) begin
            busy_d[wb_a[j]] = 1'b0;
         end
      end
      if (iss_valid_i && (iss_rd_i != '0)) begin
         busy_d[iss_rd_i] = 1'b1;
         tag_d[iss_rd_i]  = iss_tag_i;
      end
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
      tag_d[0]  = '0;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         for (int k = 0; k < NREGS; k++) begin
            regs_q[k] <= '0;
            tag_q[k]  <= '0;
         end
         busy_q    <= '0;
         wb_drop_q <= '0;
      end else begin
         regs_q    <= regs_d;
         tag_q     <= tag_d;
         busy_q    <= busy_d;
         wb_drop_q <= wb_drop_d;
      end
   end

   assign wb_drop_o = wb_drop_q;

   always_comb begin
      rd_data_o = '0;
      rd_busy_o = '0;
      for (int i = 0; i < NRD; i++) begin
         rd_a[i] = rd_addr_i[i*AW +: AW];
         rd_data_o[i*XLEN +: XLEN] = regs_q[rd_a[i]];
         rd_busy_o[i]              = busy_q[rd_a[i]];
`ifdef REGFILE_BYPASS_EN
         for (int j = 0; j < NWR; j++) begin
            if (wb_commit[j] && (wb_a[j] == rd_a[i])) begin
               rd_data_o[i*XLEN +: XLEN] = wb_w[j];
            end
            if (wb_match[j] && (wb_a[j] == rd_a[i])) begin
               rd_busy_o[i] = 1'b0;
            end
         end
`endif
         if (rd_a[i] == '0) begin
            rd_data_o[i*XLEN +: XLEN] = '0;
            rd_busy_o[i]              = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb with a per-cycle architectural model check
// plus literal expectations for each scenario.
module tb_reg_file_sb;

   localparam int XLEN = 64, NREGS = 32, NRD = 2, NWR = 2, TAG_W = 4, AW = 5;

   logic                 clk, rst_n;
   logic [NRD*AW-1:0]    rd_addr;
   logic [NRD*XLEN-1:0]  rd_data;
   logic [NRD-1:0]       rd_busy;
   logic                 iss_valid;
   logic [AW-1:0]        iss_rd;
   logic [TAG_W-1:0]     iss_tag;
   logic [NWR-1:0]       wb_valid, wb_sext32, wb_drop;
   logic [NWR*AW-1:0]    wb_addr;
   logic [NWR*XLEN-1:0]  wb_data;
   logic [NWR*TAG_W-1:0] wb_tag;
   logic                 flush;

   int total = 0;
   int bad   = 0;
   bit cmp_en = 0;

   reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .TAG_W(TAG_W)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
      .iss_valid_i(iss_valid), .iss_rd_i(iss_rd), .iss_tag_i(iss_tag),
      .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
      .wb_tag_i(wb_tag), .wb_sext32_i(wb_sext32), .wb_drop_o(wb_drop),
      .flush_i(flush)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // ---------------- architectural model ----------------
   logic [63:0] m_reg  [32];
   logic [3:0]  m_tag  [32];
   bit   [31:0] m_busy;
   bit   [1:0]  m_drop;
   logic [63:0] n_reg  [32];
   logic [3:0]  n_tag  [32];
   bit   [31:0] n_busy;
   bit   [1:0]  n_drop;

   function automatic logic [63:0] wval(input int j);
      logic [63:0] d;
      d = wb_data[j*64 +: 64];
      if (wb_sext32[j]) d = {{32{d[31]}}, d[31:0]};
      return d;
   endfunction

   function automatic bit m_commits(input int j);
      logic [4:0] a;
      a = wb_addr[j*5 +: 5];
      return wb_valid[j] && a != 0 && (!m_busy[a] || m_tag[a] == wb_tag[j*4 +: 4]);
   endfunction

   function automatic logic [63:0] exp_data(input logic [4:0] a);
      logic [63:0] d;
      if (a == 0) return 64'd0;
      d = m_reg[a];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWR; j++)
         if (m_commits(j) && wb_addr[j*5 +: 5] == a) d = wval(j);
`endif
      return d;
   endfunction

   function automatic bit exp_busy(input logic [4:0] a);
      bit b;
      if (a == 0) return 1'b0;
      b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWR; j++)
         if (m_commits(j) && wb_addr[j*5 +: 5] == a && m_busy[a]) b = 1'b0;
`endif
      return b;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < 32; k++) begin
            m_reg[k] = 64'd0;
            m_tag[k] = 4'd0;
         end
         m_busy = '0;
         m_drop = '0;
      end else begin
         n_reg  = m_reg;
         n_tag  = m_tag;
         n_busy = flush ? 32'd0 : m_busy;
         n_drop = '0;
         for (int j = 0; j < NWR; j++) begin
            if (wb_valid[j] && wb_addr[j*5 +: 5] != 0) begin
               if (m_commits(j)) begin
                  n_reg[wb_addr[j*5 +: 5]] = wval(j);
                  if (m_busy[wb_addr[j*5 +: 5]]) n_busy[wb_addr[j*5 +: 5]] = 1'b0;
               end else begin
                  n_drop[j] = 1'b1;
               end
            end
         end
         if (iss_valid && iss_rd != 0) begin
            n_busy[iss_rd] = 1'b1;
            n_tag[iss_rd]  = iss_tag;
         end
         m_reg  = n_reg;
         m_tag  = n_tag;
         m_busy = n_busy;
         m_drop = n_drop;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         for (int p = 0; p < NRD; p++) begin
            total++;
            if (rd_data[p*64 +: 64] !== exp_data(rd_addr[p*5 +: 5]) ||
                rd_busy[p] !== exp_busy(rd_addr[p*5 +: 5])) begin
               bad++;
               $display("FAIL model_rd%0d t=%0t addr=%0d got=%h/%b exp=%h/%b", p, $time,
                        rd_addr[p*5 +: 5], rd_data[p*64 +: 64], rd_busy[p],
                        exp_data(rd_addr[p*5 +: 5]), exp_busy(rd_addr[p*5 +: 5]));
            end
         end
         total++;
         if (wb_drop !== m_drop) begin
            bad++;
            $display("FAIL model_drop t=%0t got=%b exp=%b", $time, wb_drop, m_drop);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", n, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      iss_valid = 0; iss_rd = 0; iss_tag = 0;
      wb_valid = 0; wb_addr = 0; wb_data = 0; wb_tag = 0; wb_sext32 = 0;
      flush = 0;
   endtask

   task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
      rd_addr = {a1, a0};
   endtask

   task automatic wb(input int j, input logic [4:0] a, input logic [63:0] d,
                     input logic [3:0] t, input logic s);
      wb_valid[j]       = 1'b1;
      wb_addr[j*5 +: 5] = a;
      wb_data[j*64 +: 64] = d;
      wb_tag[j*4 +: 4]  = t;
      wb_sext32[j]      = s;
   endtask

   task automatic iss(input logic [4:0] r, input logic [3:0] t);
      iss_valid = 1'b1; iss_rd = r; iss_tag = t;
   endtask

   function automatic logic [63:0] rdp(input int p);
      return rd_data[p*64 +: 64];
   endfunction

   // ---------------- directed scenarios ----------------
   initial begin
      rst_n = 0; rd_addr = 0;
      idle();
      tick();
      cmp_en = 1;
      tick();
      rst_n = 1;

      // 1: reset contents, then x0 write ignored
      for (int r = 0; r < 32; r++) begin
         set_rd(5'(r), 5'(31 - r));
         #1;
         chk("reset_rd0", rdp(0), 64'd0);
         chk("reset_rd1", rdp(1), 64'd0);
         chk("reset_busy", {62'd0, rd_busy}, 64'd0);
         tick();
      end
      wb(0, 5'd0, 64'd5, 4'd0, 1'b0);
      iss(5'd0, 4'd1);
      tick(); idle(); set_rd(0, 0); #1;
      chk("x0_data", rdp(0), 64'd0);
      chk("x0_busy", {63'd0, rd_busy[0]}, 64'd0);
      tick();
      chk("x0_nodrop", {62'd0, wb_drop}, 64'd0);

      // 2: issue then matching write-back
      iss(5'd5, 4'd3);
      tick(); idle(); set_rd(5, 0); #1;
      chk("x5_busy_after_iss", {63'd0, rd_busy[0]}, 64'd1);
      wb(0, 5'd5, 64'h1234, 4'd3, 1'b0);
      tick(); idle(); #1;
      chk("x5_data", rdp(0), 64'h1234);
      chk("x5_busy", {63'd0, rd_busy[0]}, 64'd0);
      chk("x5_nodrop", {62'd0, wb_drop}, 64'd0);

      // 3: WAW re-issue makes the older write-back stale
      iss(5'd7, 4'd1);
      tick(); iss(5'd7, 4'd2);
      tick(); idle(); wb(0, 5'd7, 64'hAA, 4'd1, 1'b0);
      tick(); idle(); set_rd(7, 7); #1;
      chk("x7_drop", {62'd0, wb_drop}, 64'd1);
      chk("x7_still_busy", {63'd0, rd_busy[1]}, 64'd1);
      chk("x7_unwritten", rdp(0), 64'd0);
      wb(0, 5'd7, 64'hBB, 4'd2, 1'b0);
      tick(); idle(); #1;
      chk("x7_data", rdp(0), 64'hBB);
      chk("x7_busy_clr", {63'd0, rd_busy[0]}, 64'd0);
      chk("x7_nodrop", {62'd0, wb_drop}, 64'd0);

      // 4: sign extension vs. full-width write
      wb(0, 5'd9,  64'h0000_0000_8000_0001, 4'd0, 1'b1);
      wb(1, 5'd10, 64'h0000_0000_8000_0001, 4'd0, 1'b0);
      tick(); idle(); set_rd(9, 10); #1;
      chk("x9_sext", rdp(0), 64'hFFFF_FFFF_8000_0001);
      chk("x10_full", rdp(1), 64'h0000_0000_8000_0001);
      wb(1, 5'd10, 64'hDEAD_BEEF_7FFF_FFFF, 4'd0, 1'b1);
      tick(); idle(); #1;
      chk("x10_sext_pos", rdp(1), 64'h0000_0000_7FFF_FFFF);

      // 5: same-address collision, then flush with issue/write-back concurrent
      wb(0, 5'd3, 64'h11, 4'd0, 1'b0);
      wb(1, 5'd3, 64'h22, 4'd0, 1'b0);
      tick(); idle(); set_rd(3, 0); #1;
      chk("x3_hi_port_wins", rdp(0), 64'h22);
      for (int r = 11; r <= 14; r++) begin
         iss(5'(r), 4'(r - 10));
         tick();
      end
      idle(); set_rd(11, 14); #1;
      chk("pre_flush_busy", {62'd0, rd_busy}, 64'd3);
      flush = 1;
      wb(0, 5'd11, 64'h31, 4'd1, 1'b0);
      iss(5'd15, 4'd7);
      tick(); idle(); set_rd(11, 12); #1;
      chk("flush_busy_a", {62'd0, rd_busy}, 64'd0);
      chk("flush_wb_commit", rdp(0), 64'h31);
      set_rd(13, 15); #1;
      chk("flush_busy_b", {63'd0, rd_busy[0]}, 64'd0);
      chk("flush_iss_wins", {63'd0, rd_busy[1]}, 64'd1);
      tick();

      // 6: same-cycle visibility of a write
      wb(0, 5'd4, 64'h55, 4'd0, 1'b0);
      set_rd(4, 4); #1;
`ifdef REGFILE_BYPASS_EN
      chk("bypass_same_cycle", rdp(0), 64'h55);
`else
      chk("nobypass_same_cycle", rdp(0), 64'd0);
`endif
      tick(); idle(); #1;
      chk("x4_next_cycle", rdp(1), 64'h55);

      // issue and matching write-back to the same register in one cycle
      iss(5'd20, 4'd5);
      tick(); idle();
      wb(1, 5'd20, 64'h77, 4'd5, 1'b0);
      iss(5'd20, 4'd6);
      tick(); idle(); set_rd(20, 20); #1;
      chk("x20_data", rdp(0), 64'h77);
      chk("x20_rebusy", {63'd0, rd_busy[0]}, 64'd1);
      wb(1, 5'd20, 64'h88, 4'd5, 1'b0);
      tick(); idle(); #1;
      chk("x20_stale_drop", {62'd0, wb_drop}, 64'd2);
      chk("x20_kept", rdp(1), 64'h77);

      // reset mid-operation discards pending busy state
      iss(5'd21, 4'd1);
      tick(); idle(); rst_n = 0;
      tick(); rst_n = 1; set_rd(21, 20); #1;
      chk("rst_busy", {62'd0, rd_busy}, 64'd0);
      chk("rst_data", rdp(1), 64'd0);
      wb(0, 5'd21, 64'h99, 4'd9, 1'b0);
      tick(); idle(); #1;
      chk("post_rst_commit", rdp(0), 64'h99);
      tick();
      chk("post_rst_nodrop", {62'd0, wb_drop}, 64'd0);

      tick();
      cmp_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
